// File: rtl/matrix_stream_buf.sv
// matrix_stream_buf: buffers one NROW x NCOL matrix from a row-major element
// stream and replays it in row-major or column-major order, chosen per frame.
//
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   i_valid/i_ready   input element handshake
//   i_data            input element, row-major
//   i_tp              frame order, sampled on first accepted element
//   o_valid/o_ready   output element handshake
//   o_data            output element (registered)
//   o_line_last       last element of an output line
//   o_frame_last      last element of the frame
//   busy              frame in progress (FILL or DRAIN)

module matrix_stream_buf #(
  parameter int DW   = 8,
  parameter int NROW = 3,
  parameter int NCOL = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_valid,
  output logic          i_ready,
  input  logic [DW-1:0] i_data,
  input  logic          i_tp,
  output logic          o_valid,
  input  logic          o_ready,
  output logic [DW-1:0] o_data,
  output logic          o_line_last,
  output logic          o_frame_last,
  output logic          busy
);

  localparam int N  = NROW * NCOL;
  localparam int RW = (NROW > 1) ? $clog2(NROW) : 1;
  localparam int CW = (NCOL > 1) ? $clog2(NCOL) : 1;
  localparam int AW = (N > 1) ? $clog2(N) : 1;

  localparam logic [RW-1:0] RMAX = RW'(NROW - 1);
  localparam logic [CW-1:0] CMAX = CW'(NCOL - 1);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    DRAIN
  } state_t;

  state_t        state;
  logic [RW-1:0] r;
  logic [CW-1:0] c;
  logic          tp_q;

  logic [DW-1:0] mem [N];

  logic          in_hs;
  logic          out_hs;
  logic          at_last;
  logic          tp_now;

  logic [RW-1:0] rm_r;
  logic [CW-1:0] rm_c;
  logic [RW-1:0] cm_r;
  logic [CW-1:0] cm_c;
  logic [RW-1:0] nr;
  logic [CW-1:0] nc;

  logic [DW-1:0] first_data;
  logic          first_line;
  logic          first_frame;
  logic [DW-1:0] next_data;
  logic          next_line;
  logic          next_frame;

  function automatic logic [AW-1:0] idx(
    input logic [RW-1:0] pr,
    input logic [CW-1:0] pc
  );
    int lin;
    lin = int'(pr) * NCOL + int'(pc);
    return AW'(lin);
  endfunction

  assign i_ready = (state != DRAIN);
  assign in_hs   = i_valid && i_ready;
  assign out_hs  = o_valid && o_ready;
  assign at_last = (r == RMAX) && (c == CMAX);

  // Order is latched on the first element; that element arrives in IDLE.
  assign tp_now = (state == IDLE) ? i_tp : tp_q;

  // Successor positions in both scan orders.
  always_comb begin
    rm_r = r;
    rm_c = c + CW'(1);
    if (c == CMAX) begin
      rm_c = '0;
      rm_r = r + RW'(1);
    end
    cm_c = c;
    cm_r = r + RW'(1);
    if (r == RMAX) begin
      cm_r = '0;
      cm_c = c + CW'(1);
    end
    nr = tp_q ? cm_r : rm_r;
    nc = tp_q ? cm_c : rm_c;
  end

  // Element (0,0) preloaded on entry to DRAIN. A 1x1 frame enters DRAIN on
  // the same edge that writes its only element, so bypass the array.
  always_comb begin
    first_data  = (N == 1) ? i_data : mem[0];
    first_line  = tp_now ? (NROW == 1) : (NCOL == 1);
    first_frame = (N == 1);
  end

  always_comb begin
    next_data  = mem[idx(nr, nc)];
    next_line  = tp_q ? (nr == RMAX) : (nc == CMAX);
    next_frame = (nr == RMAX) && (nc == CMAX);
  end

  always_ff @(posedge clk) begin
    if (in_hs) begin
      mem[idx(r, c)] <= i_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      r            <= '0;
      c            <= '0;
      tp_q         <= 1'b0;
      o_valid      <= 1'b0;
      o_data       <= '0;
      o_line_last  <= 1'b0;
      o_frame_last <= 1'b0;
      busy         <= 1'b0;
    end else begin
      unique case (state)
        IDLE, FILL: begin
          if (in_hs) begin
            busy <= 1'b1;
            if (state == IDLE) begin
              tp_q <= i_tp;
            end
            if (at_last) begin
              state        <= DRAIN;
              r            <= '0;
              c            <= '0;
              o_valid      <= 1'b1;
              o_data       <= first_data;
              o_line_last  <= first_line;
              o_frame_last <= first_frame;
            end else begin
              state <= FILL;
              r     <= rm_r;
              c     <= rm_c;
            end
          end
        end
        DRAIN: begin
          if (out_hs) begin
            if (o_frame_last) begin
              state        <= IDLE;
              r            <= '0;
              c            <= '0;
              o_valid      <= 1'b0;
              o_data       <= '0;
              o_line_last  <= 1'b0;
              o_frame_last <= 1'b0;
              busy         <= 1'b0;
            end else begin
              r            <= nr;
              c            <= nc;
              o_data       <= next_data;
              o_line_last  <= next_line;
              o_frame_last <= next_frame;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_stream_buf.sv
// tb_matrix_stream_buf: directed checks of matrix_stream_buf for a 3x4
// instance and a 1x1 instance.

module tb_matrix_stream_buf;

  logic       clk = 1'b0;
  logic       rst;

  logic       i_valid;
  logic       i_ready;
  logic [7:0] i_data;
  logic       i_tp;
  logic       o_valid;
  logic       o_ready;
  logic [7:0] o_data;
  logic       o_line_last;
  logic       o_frame_last;
  logic       busy;

  logic       s_i_valid;
  logic       s_i_ready;
  logic [7:0] s_i_data;
  logic       s_i_tp;
  logic       s_o_valid;
  logic       s_o_ready;
  logic [7:0] s_o_data;
  logic       s_o_line_last;
  logic       s_o_frame_last;
  logic       s_busy;

  int checks = 0;
  int failures = 0;

  logic [7:0] ed [12];
  logic       el [12];
  logic       ef [12];

  always #5 clk = ~clk;

  matrix_stream_buf #(
    .DW  (8),
    .NROW(3),
    .NCOL(4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_valid     (i_valid),
    .i_ready     (i_ready),
    .i_data      (i_data),
    .i_tp        (i_tp),
    .o_valid     (o_valid),
    .o_ready     (o_ready),
    .o_data      (o_data),
    .o_line_last (o_line_last),
    .o_frame_last(o_frame_last),
    .busy        (busy)
  );

  matrix_stream_buf #(
    .DW  (8),
    .NROW(1),
    .NCOL(1)
  ) dut1 (
    .clk         (clk),
    .rst         (rst),
    .i_valid     (s_i_valid),
    .i_ready     (s_i_ready),
    .i_data      (s_i_data),
    .i_tp        (s_i_tp),
    .o_valid     (s_o_valid),
    .o_ready     (s_o_ready),
    .o_data      (s_o_data),
    .o_line_last (s_o_line_last),
    .o_frame_last(s_o_frame_last),
    .busy        (s_busy)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected output sequence for a 3x4 frame holding base + r*4 + c.
  task automatic build(input int base, input logic tp);
    int k;
    k = 0;
    if (!tp) begin
      for (int rr = 0; rr < 3; rr++) begin
        for (int cc = 0; cc < 4; cc++) begin
          ed[k] = 8'(base + rr * 4 + cc);
          el[k] = (cc == 3);
          ef[k] = (rr == 2) && (cc == 3);
          k++;
        end
      end
    end else begin
      for (int cc = 0; cc < 4; cc++) begin
        for (int rr = 0; rr < 3; rr++) begin
          ed[k] = 8'(base + rr * 4 + cc);
          el[k] = (rr == 2);
          ef[k] = (rr == 2) && (cc == 3);
          k++;
        end
      end
    end
  endtask

  task automatic send(
    input int   base,
    input logic tp0,
    input logic tp_rest,
    input bit   gaps
  );
    int k;
    int g;
    bit pat [5];
    pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    k = 0;
    g = 0;
    while (k < 12) begin
      @(negedge clk);
      if (gaps && !pat[g % 5]) begin
        i_valid = 1'b0;
        i_data  = 8'hFF;
        i_tp    = ~tp0;
      end else begin
        i_valid = 1'b1;
        i_data  = 8'(base + k);
        i_tp    = (k == 0) ? tp0 : tp_rest;
        chk("fill_i_ready", i_ready, 1);
        chk("fill_busy", busy, (k == 0) ? 0 : 1);
        chk("fill_o_valid", o_valid, 0);
        k++;
      end
      g++;
    end
  endtask

  task automatic drain(
    input int stop_after,
    input bit use_pat,
    input bit junk
  );
    int got;
    int cyc;
    bit rp [6];
    rp = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    got = 0;
    cyc = 0;
    while (got < stop_after && cyc < 200) begin
      @(negedge clk);
      i_valid = junk;
      i_data  = 8'hEE;
      o_ready = use_pat ? rp[cyc % 6] : 1'b1;
      chk("drain_o_valid", o_valid, 1);
      chk("drain_o_data", o_data, ed[got]);
      chk("drain_line_last", o_line_last, el[got]);
      chk("drain_frame_last", o_frame_last, ef[got]);
      chk("drain_i_ready", i_ready, 0);
      chk("drain_busy", busy, 1);
      if (o_ready) got++;
      cyc++;
    end
    if (got < stop_after) begin
      chk("drain_timeout", got, stop_after);
    end
  endtask

  task automatic end_check(input string tag);
    @(negedge clk);
    i_valid = 1'b0;
    chk({tag, "_o_valid"}, o_valid, 0);
    chk({tag, "_i_ready"}, i_ready, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_o_data"}, o_data, 0);
    chk({tag, "_line_last"}, o_line_last, 0);
    chk({tag, "_frame_last"}, o_frame_last, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] sd [3];
    sd = '{8'h5A, 8'h3C, 8'hA5};

    rst       = 1'b0;
    i_valid   = 1'b0;
    i_data    = '0;
    i_tp      = 1'b0;
    o_ready   = 1'b1;
    s_i_valid = 1'b0;
    s_i_data  = '0;
    s_i_tp    = 1'b0;
    s_o_ready = 1'b1;

    repeat (2) @(negedge clk);
    chk("rst_o_valid", o_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_o_data", o_data, 0);
    chk("rst_line_last", o_line_last, 0);
    chk("rst_frame_last", o_frame_last, 0);
    rst = 1'b1;
    #1;
    chk("rst_i_ready", i_ready, 1);

    // Row-major, back-to-back input, o_ready held high.
    build(0, 1'b0);
    send(0, 1'b0, 1'b0, 1'b0);
    drain(12, 1'b0, 1'b0);
    end_check("t1_end");

    // Column-major.
    build(0, 1'b1);
    send(0, 1'b1, 1'b1, 1'b0);
    drain(12, 1'b0, 1'b0);
    end_check("t2_end");

    // i_tp toggled after first element, gaps in i_valid.
    build(0, 1'b0);
    send(0, 1'b0, 1'b1, 1'b1);
    drain(12, 1'b0, 1'b0);
    end_check("t3_end");

    // Output stalls, junk input offered while draining.
    build(20, 1'b0);
    send(20, 1'b0, 1'b0, 1'b0);
    drain(12, 1'b1, 1'b1);
    end_check("t4_end");

    // Reset in the middle of a drain, then a fresh column-major frame.
    build(0, 1'b0);
    send(0, 1'b0, 1'b0, 1'b0);
    drain(5, 1'b0, 1'b0);
    @(negedge clk);
    i_valid = 1'b0;
    rst     = 1'b0;
    #1;
    chk("t5_rst_o_valid", o_valid, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_o_data", o_data, 0);
    chk("t5_rst_frame_last", o_frame_last, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("t5_rel_i_ready", i_ready, 1);
    chk("t5_rel_o_valid", o_valid, 0);
    chk("t5_rel_busy", busy, 0);
    build(100, 1'b1);
    send(100, 1'b1, 1'b1, 1'b0);
    drain(12, 1'b0, 1'b0);
    end_check("t5_end");

    // 1x1 instance: one element every two cycles with input held valid.
    for (int f = 0; f < 3; f++) begin
      @(negedge clk);
      s_i_valid = 1'b1;
      s_i_data  = sd[f];
      chk("t6_idle_i_ready", s_i_ready, 1);
      chk("t6_idle_o_valid", s_o_valid, 0);
      chk("t6_idle_busy", s_busy, 0);
      @(negedge clk);
      s_i_data = 8'h00;
      chk("t6_o_valid", s_o_valid, 1);
      chk("t6_o_data", s_o_data, sd[f]);
      chk("t6_line_last", s_o_line_last, 1);
      chk("t6_frame_last", s_o_frame_last, 1);
      chk("t6_i_ready", s_i_ready, 0);
      chk("t6_busy", s_busy, 1);
    end
    @(negedge clk);
    s_i_valid = 1'b0;
    chk("t6_end_o_valid", s_o_valid, 0);
    chk("t6_end_o_data", s_o_data, 0);
    chk("t6_end_i_ready", s_i_ready, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
